// File: rtl/branch_resolution_pkg.sv
// Shared types and constants for the branch resolution path.
// The entry record is reused by the predictor integration and the hazard unit.
package branch_resolution_pkg;

    localparam int BRU_ADDR_WIDTH = 6;
    localparam int BRU_PC_WIDTH   = 32;
    localparam int BRU_DEPTH      = 4;
    localparam int BRU_PTR_WIDTH  = $clog2(BRU_DEPTH);

    typedef struct packed {
        logic [BRU_ADDR_WIDTH-1:0] addr;
        logic                      predTaken;
        logic [BRU_PC_WIDTH-1:0]   altPC;
    } bru_entry_t;

    // Pointer width for a queue of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/branch_resolution_fifo.sv
// Generic circular buffer with push, pop and clear; DEPTH must be a power of 2.
// clear equalises the pointers at the post-pop head, so a same-cycle pop still retires.
module branch_resolution_fifo
    import branch_resolution_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_next;
    logic [PW:0]      occ;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full      = (occ == (PW+1)'(DEPTH));
    assign empty     = (occ == '0);
    assign count     = occ;
    assign rdata     = mem[head];

    // Pushes into a full queue and pops from an empty one are silently ignored.
    assign do_pop    = pop && !empty;
    assign do_push   = push && !full && !clear;
    assign head_next = head + PW'(do_pop);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head_next;
            if (clear) begin
                tail <= head_next;
                occ  <= '0;
            end else begin
                if (do_push) begin
                    tail <= tail + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   occ <= occ + (PW+1)'(1);
                    2'b01:   occ <= occ - (PW+1)'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= wdata;
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Tracks in-flight branch predictions, trains the 2-bit predictor on resolve
// and redirects fetch on a mispredict.
module branch_resolution_unit
    import branch_resolution_pkg::*;
#(
    parameter int ADDR_WIDTH = BRU_ADDR_WIDTH,
    parameter int PC_WIDTH   = BRU_PC_WIDTH,
    parameter int DEPTH      = BRU_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   predValid,
    input  logic [ADDR_WIDTH-1:0]  predAddr,
    input  logic                   predTaken,
    input  logic [PC_WIDTH-1:0]    predAltPC,
    output logic                   predReady,
    input  logic                   resolveValid,
    input  logic                   resolveTaken,
    input  logic                   flush,
    output logic [ADDR_WIDTH-1:0]  updateAddr,
    output logic                   branchTaken,
    output logic                   update,
    output logic                   mispredict,
    output logic [PC_WIDTH-1:0]    redirectPC,
    output logic [$clog2(DEPTH):0] count,
    output logic                   resolveErr
);

    localparam int EW = ADDR_WIDTH + 1 + PC_WIDTH;

    logic [EW-1:0]         wr_entry;
    logic [EW-1:0]         head_entry;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  head_taken;
    logic [PC_WIDTH-1:0]   head_alt;
    logic                  full;
    logic                  empty;
    logic                  resolve_hit;
    logic                  wrong_path;
    logic                  push_en;
    logic                  clear_q;

    assign wr_entry   = {predAddr, predTaken, predAltPC};
    assign head_addr  = head_entry[EW-1 -: ADDR_WIDTH];
    assign head_taken = head_entry[PC_WIDTH];
    assign head_alt   = head_entry[PC_WIDTH-1:0];

    assign predReady   = rst && !full;
    assign resolve_hit = resolveValid && !empty;
    assign wrong_path  = resolve_hit && (resolveTaken != head_taken);

    // A mispredict squashes everything younger, including a push arriving in the same cycle.
    assign push_en     = predValid && predReady && !flush && !wrong_path;
    assign clear_q     = flush || wrong_path;

    branch_resolution_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .pop   (resolve_hit),
        .clear (clear_q),
        .wdata (wr_entry),
        .rdata (head_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Address, direction and redirect hold their last values between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update      <= 1'b0;
            mispredict  <= 1'b0;
            resolveErr  <= 1'b0;
            updateAddr  <= '0;
            branchTaken <= 1'b0;
            redirectPC  <= '0;
        end else begin
            update     <= resolve_hit;
            mispredict <= wrong_path;
            resolveErr <= resolveValid && empty;
            if (resolve_hit) begin
                updateAddr  <= head_addr;
                branchTaken <= resolveTaken;
            end
            if (wrong_path) begin
                redirectPC <= head_alt;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_branch_resolution_unit;
    import branch_resolution_pkg::*;

    localparam int AW    = 6;
    localparam int PW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          predValid;
    logic [AW-1:0] predAddr;
    logic          predTaken;
    logic [PW-1:0] predAltPC;
    logic          predReady;
    logic          resolveValid;
    logic          resolveTaken;
    logic          flush;
    logic [AW-1:0] updateAddr;
    logic          branchTaken;
    logic          update;
    logic          mispredict;
    logic [PW-1:0] redirectPC;
    logic [2:0]    count;
    logic          resolveErr;

    always #5 clk = ~clk;

    branch_resolution_unit #(
        .ADDR_WIDTH (AW),
        .PC_WIDTH   (PW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .predValid    (predValid),
        .predAddr     (predAddr),
        .predTaken    (predTaken),
        .predAltPC    (predAltPC),
        .predReady    (predReady),
        .resolveValid (resolveValid),
        .resolveTaken (resolveTaken),
        .flush        (flush),
        .updateAddr   (updateAddr),
        .branchTaken  (branchTaken),
        .update       (update),
        .mispredict   (mispredict),
        .redirectPC   (redirectPC),
        .count        (count),
        .resolveErr   (resolveErr)
    );

    typedef struct {
        bit            upd;
        bit            mis;
        bit            err;
        logic [AW-1:0] addr;
        bit            tk;
        logic [PW-1:0] redir;
        int            cnt;
    } exp_t;

    exp_t          exp_q[$];
    bru_entry_t    model_q[$];
    logic [AW-1:0] last_addr  = '0;
    bit            last_tk    = 1'b0;
    logic [PW-1:0] last_redir = '0;
    int            n_checks   = 0;
    int            n_fail     = 0;
    bit            mon_en     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("update",      64'(update),      64'(e.upd));
            check("mispredict",  64'(mispredict),  64'(e.mis));
            check("resolveErr",  64'(resolveErr),  64'(e.err));
            check("updateAddr",  64'(updateAddr),  64'(e.addr));
            check("branchTaken", 64'(branchTaken), 64'(e.tk));
            check("redirectPC",  64'(redirectPC),  64'(e.redir));
            check("count",       64'(count),       64'(e.cnt));
            check("predReady",   64'(predReady),   64'(e.cnt != DEPTH));
        end
    end

    // Drive one cycle of stimulus and record what the outputs must be after the edge.
    task automatic cycle(input bit pv, input logic [AW-1:0] pa, input bit pt, input logic [PW-1:0] palt,
                         input bit rv, input bit rt, input bit fl);
        exp_t       e;
        bru_entry_t h;
        int         sz;
        @(negedge clk);
        #1;
        predValid    = pv;
        predAddr     = pa;
        predTaken    = pt;
        predAltPC    = palt;
        resolveValid = rv;
        resolveTaken = rt;
        flush        = fl;

        sz    = model_q.size();
        e.upd = 0;
        e.mis = 0;
        e.err = 0;
        if (rv && sz > 0) begin
            h         = model_q.pop_front();
            e.upd     = 1;
            last_addr = h.addr;
            last_tk   = rt;
            if (rt != h.predTaken) begin
                e.mis      = 1;
                last_redir = h.altPC;
                model_q.delete();
            end
        end else if (rv) begin
            e.err = 1;
        end
        if (fl) model_q.delete();
        if (pv && sz < DEPTH && !fl && !e.mis)
            model_q.push_back(bru_entry_t'{addr: pa, predTaken: pt, altPC: palt});
        e.addr  = last_addr;
        e.tk    = last_tk;
        e.redir = last_redir;
        e.cnt   = model_q.size();
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [AW-1:0] a, input bit t, input logic [PW-1:0] alt);
        cycle(1, a, t, alt, 0, 0, 0);
    endtask

    task automatic resolve(input bit t);
        cycle(0, '0, 0, '0, 1, t, 0);
    endtask

    task automatic idle();
        cycle(0, '0, 0, '0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".count"},      64'(count),       64'd0);
        check({tag, ".update"},     64'(update),      64'd0);
        check({tag, ".mispredict"}, 64'(mispredict),  64'd0);
        check({tag, ".resolveErr"}, 64'(resolveErr),  64'd0);
        check({tag, ".updateAddr"}, 64'(updateAddr),  64'd0);
        check({tag, ".branchTaken"},64'(branchTaken), 64'd0);
        check({tag, ".redirectPC"}, 64'(redirectPC),  64'd0);
        check({tag, ".predReady"},  64'(predReady),   64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        predValid    = 1'b0;
        predAddr     = '0;
        predTaken    = 1'b0;
        predAltPC    = '0;
        resolveValid = 1'b0;
        resolveTaken = 1'b0;
        flush        = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("predReady_after_reset", 64'(predReady), 64'd1);
        mon_en = 1'b1;

        // Correct resolve of a single entry.
        push(5, 1, 32'h104);
        resolve(1);
        idle();

        // Mispredict on the oldest of three; the concurrent push is wrong-path.
        push(3, 0, 32'h200);
        push(7, 1, 32'h280);
        push(9, 0, 32'h300);
        cycle(1, 11, 1, 32'h340, 1, 1, 0);
        idle();

        // Fill to capacity, attempt an overflow push, drain in order across the wrap.
        push(10, 1, 32'h400);
        push(12, 0, 32'h410);
        push(13, 1, 32'h420);
        push(14, 0, 32'h430);
        push(15, 1, 32'h440);
        resolve(1);
        resolve(0);
        resolve(1);
        resolve(0);
        idle();

        // Correct resolve with a simultaneous push keeps occupancy at two.
        push(20, 0, 32'h500);
        push(21, 1, 32'h510);
        cycle(1, 22, 0, 32'h520, 1, 0, 0);
        resolve(1);
        resolve(0);
        idle();

        // Resolve on empty, then flush with three entries and a blocked push.
        resolve(1);
        idle();
        push(30, 1, 32'h600);
        push(31, 0, 32'h610);
        push(32, 1, 32'h620);
        cycle(1, 33, 0, 32'h630, 0, 0, 1);
        idle();

        // Flush combined with a correct resolve still emits that resolve's update.
        push(34, 1, 32'h640);
        push(35, 0, 32'h650);
        cycle(0, 0, 0, 0, 1, 1, 1);
        idle();

        // Asynchronous reset mid-stream with three entries and a live update pulse.
        push(40, 1, 32'h700);
        push(41, 0, 32'h710);
        push(42, 1, 32'h720);
        cycle(1, 43, 0, 32'h730, 1, 1, 0);
        @(negedge clk);
        #3;
        mon_en       = 1'b0;
        rst          = 1'b0;
        predValid    = 1'b0;
        resolveValid = 1'b0;
        flush        = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        model_q.delete();
        last_addr  = '0;
        last_tk    = 1'b0;
        last_redir = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("predReady_after_release", 64'(predReady), 64'd1);
        mon_en = 1'b1;
        push(44, 0, 32'h740);
        resolve(0);
        idle();

        // Randomized traffic, biased towards correct resolves so the queue stays busy.
        for (int i = 0; i < 500; i++) begin
            bit rt;
            if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
                rt = model_q[0].predTaken;
            else
                rt = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 99) < 60, AW'($urandom), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 99) < 40, rt, $urandom_range(0, 99) < 3);
        end

        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Companion to the 2-bit branch predictor: the training and recovery side of the predictor's update interface.
- Records every branch prediction issued at fetch in an in-order queue. When execute resolves a branch, compares the actual outcome against the recorded prediction.
- Drives the predictor's updateAddr/branchTaken/update port set, plus a mispredict redirect to fetch.

Parameters:
- ADDR_WIDTH, 6: predictor index width; matches the predictor.
- PC_WIDTH, 32: width of the recovery PC.
- DEPTH, 4: number of outstanding unresolved branches; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- predValid  in  1  fetch issued a prediction for a branch this cycle
- predAddr  in  ADDR_WIDTH  predictor index used for that prediction
- predTaken  in  1  predicted direction
- predAltPC  in  PC_WIDTH  recovery PC: target if predicted not-taken, fall-through if predicted taken
- predReady  out  1  queue can accept a push; equals !full
- resolveValid  in  1  execute resolved the oldest outstanding branch
- resolveTaken  in  1  actual direction
- flush  in  1  external pipeline flush (exception); discards all entries
- updateAddr  out  ADDR_WIDTH  to predictor
- branchTaken  out  1  to predictor
- update  out  1  to predictor; one-cycle pulse
- mispredict  out  1  one-cycle pulse to fetch/hazard unit
- redirectPC  out  PC_WIDTH  valid when mispredict=1
- count  out  clog2(DEPTH)+1  occupancy
- resolveErr  out  1  one-cycle pulse: resolveValid arrived with the queue empty

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, count=0, all outputs 0 (predReady=1 once rst=1). The queue contents array has no reset requirement.
- Queue:
  - circular buffer, log2(DEPTH)-bit head/tail pointers wrapping at DEPTH
  - entry = {addr, predTaken, altPC}
  - push on posedge when predValid && predReady; a push while full is dropped with no state change
- Resolve (resolveValid && count!=0):
  - pops the head entry
  - outputs are registered with 1-cycle latency: next cycle update=1, updateAddr=head.addr, branchTaken=resolveTaken
  - mispredict=1 and redirectPC=head.altPC if resolveTaken!=head.predTaken; otherwise mispredict=0 and redirectPC holds its old value
- Mispredicting resolve:
  - all younger entries are discarded: tail=head+1, count=0 after the edge
  - a push in the same cycle is wrong-path and is dropped
- Correct resolve with simultaneous push: count unchanged; both pointers advance.
- flush=1: pointers equalised, count=0; pushes that cycle are dropped.
  - A resolve in the same cycle still pops and emits update/mispredict from the current head.
  - flush takes priority only over queue contents, not over that cycle's resolve outputs.
- resolveValid with count==0: ignored; resolveErr=1 next cycle; update=0.
- update, mispredict and resolveErr are high for exactly one cycle per event and return to 0 otherwise.
- Reset mid-operation: queue emptied immediately; any pending update pulse is lost. The predictor's own reset restores its counters separately.
- Ordering guarantee: resolves are strictly in push order. No tagging is needed.

Decomposition:
- Shared package: the entry record type {addr, predTaken, altPC} and a DEPTH-derived pointer-width constant (clog2). Both are reused by the predictor integration and the hazard unit.
- One sub-module: branch_resolution_fifo. It is the generic circular buffer with push, pop and clear ports and count/full/empty. branch_resolution_unit wraps it with the compare, pulse registers and drop rules.

Test Plan:
- After reset: push addr=5, taken=1, alt=0x104; then resolve taken=1 -> next cycle update=1, updateAddr=5, branchTaken=1, mispredict=0, count=0.
- Push addr=3, taken=0, alt=0x200, then addr=7, then addr=9; resolve taken=1 -> next cycle mispredict=1, redirectPC=0x200, updateAddr=3, count=0; a push in the resolve cycle is not stored.
- Push 4 entries (DEPTH=4) -> predReady=0; a 5th push is dropped. Resolve all 4 correctly -> updateAddr sequence equals push order and pointers wrap; count ends at 0.
- Simultaneous correct resolve and push at count=2 -> count stays 2; next resolve returns the second-oldest addr.
- resolveValid with empty queue -> resolveErr=1 for one cycle, update=0. Then flush with 3 entries -> count=0 next cycle and no update pulse.
- Assert rst=0 asynchronously mid-stream with count=3 -> count=0 and all outputs 0 without waiting for a clock edge; first push after release is accepted.
